parking_sensor_tracker: RTL and testbench

//  Consumer of the 100 Hz tick from the slow-clock divider. Debounces the raw entry and

---
 rtl/parking_pkg.sv | 17 +
 rtl/sensor_debounce.sv | 87 ++++++++
 rtl/parking_sensor_tracker.sv | 91 +++++++++
 tb/tb_parking_sensor_tracker.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared definitions for the parking sensor path: debounce state encodings and
// default lot sizing reused by the tracker, display and gate blocks.
`timescale 1ns/1ps
package parking_pkg;

  localparam int CAPACITY_DEF    = 8;
  localparam int CNT_W_DEF       = 4;
  localparam int DEB_SAMPLES_DEF = 4;

  typedef enum logic [1:0] {
    LOW     = 2'd0,
    CONF_HI = 2'd1,
    HIGH    = 2'd2,
    CONF_LO = 2'd3
  } deb_state_t;

endpackage

// File: rtl/sensor_debounce.sv
// One sensor channel: 2-flop synchronizer, tick-qualified debounce FSM with a
// sample counter, and a one-clock pulse on each accepted low-to-high change.
`timescale 1ns/1ps
module sensor_debounce
  import parking_pkg::*;
#(
  parameter int DEB_SAMPLES = DEB_SAMPLES_DEF
) (
  input  logic clk_in,
  input  logic rst,
  input  logic tick_100hz,
  input  logic raw,
  output logic rise
);

  localparam int CNT_DW = $clog2(DEB_SAMPLES + 1);
  localparam logic [CNT_DW-1:0] DEB_LAST = CNT_DW'(DEB_SAMPLES);

  logic              sync_p0;
  logic              sync_p1;
  deb_state_t        state;
  logic [CNT_DW-1:0] cnt;
  logic [CNT_DW-1:0] cnt_inc;

  assign cnt_inc = cnt + 1'b1;

  // Synchronize the raw level, then advance the debounce FSM on each tick; a
  // level change is accepted on the tick where the count of agreeing samples
  // reaches DEB_SAMPLES, and rise fires in the first cycle spent in HIGH.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      state   <= LOW;
      cnt     <= '0;
      rise    <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      rise    <= 1'b0;
      if (tick_100hz) begin
        case (state)
          LOW: begin
            if (sync_p1) begin
              state <= CONF_HI;
              cnt   <= CNT_DW'(1);
            end
          end
          CONF_HI: begin
            if (sync_p1) begin
              cnt <= cnt_inc;
              if (cnt_inc == DEB_LAST) begin
                state <= HIGH;
                rise  <= 1'b1;
              end
            end else begin
              state <= LOW;
              cnt   <= '0;
            end
          end
          HIGH: begin
            if (!sync_p1) begin
              state <= CONF_LO;
              cnt   <= CNT_DW'(1);
            end
          end
          CONF_LO: begin
            if (!sync_p1) begin
              cnt <= cnt_inc;
              if (cnt_inc == DEB_LAST) begin
                state <= LOW;
              end
            end else begin
              state <= HIGH;
              cnt   <= '0;
            end
          end
          default: begin
            state <= LOW;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/parking_sensor_tracker.sv
// Parking occupancy tracker: debounces entry/exit IR sensors on the 100 Hz
// enable and keeps a saturating car count with full/empty/free-slot status.
`timescale 1ns/1ps
module parking_sensor_tracker
  import parking_pkg::*;
#(
  parameter int CAPACITY    = CAPACITY_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEB_SAMPLES = DEB_SAMPLES_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             tick_100hz,
  input  logic             entry_raw,
  input  logic             exit_raw,
  output logic [CNT_W-1:0] occupied,
  output logic [CNT_W-1:0] free_slots,
  output logic             full,
  output logic             empty,
  output logic             entry_evt,
  output logic             exit_evt,
  output logic             reject,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

  logic entry_rise;
  logic exit_rise;

  sensor_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_entry_deb (
    .clk_in     (clk_in),
    .rst        (rst),
    .tick_100hz (tick_100hz),
    .raw        (entry_raw),
    .rise       (entry_rise)
  );

  sensor_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_exit_deb (
    .clk_in     (clk_in),
    .rst        (rst),
    .tick_100hz (tick_100hz),
    .raw        (exit_raw),
    .rise       (exit_rise)
  );

  assign full       = (occupied == CAP);
  assign empty      = (occupied == '0);
  assign free_slots = CAP - occupied;

  // Apply accepted arrivals to the saturating count; a simultaneous entry and
  // exit cancel out and are both reported regardless of full/empty.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      occupied  <= '0;
      entry_evt <= 1'b0;
      exit_evt  <= 1'b0;
      reject    <= 1'b0;
      underflow <= 1'b0;
    end else begin
      entry_evt <= 1'b0;
      exit_evt  <= 1'b0;
      reject    <= 1'b0;
      underflow <= 1'b0;
      case ({entry_rise, exit_rise})
        2'b11: begin
          entry_evt <= 1'b1;
          exit_evt  <= 1'b1;
        end
        2'b10: begin
          if (full) begin
            reject <= 1'b1;
          end else begin
            occupied  <= occupied + 1'b1;
            entry_evt <= 1'b1;
          end
        end
        2'b01: begin
          if (empty) begin
            underflow <= 1'b1;
          end else begin
            occupied <= occupied - 1'b1;
            exit_evt <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_parking_sensor_tracker.sv
// Directed bench for parking_sensor_tracker with a tick every 10 clocks.
`timescale 1ns/1ps
module tb_parking_sensor_tracker;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       tick_100hz = 1'b0;
  logic       entry_raw = 1'b0;
  logic       exit_raw = 1'b0;
  logic [3:0] occupied;
  logic [3:0] free_slots;
  logic       full;
  logic       empty;
  logic       entry_evt;
  logic       exit_evt;
  logic       reject;
  logic       underflow;

  int total = 0;
  int bad = 0;
  int phase = 0;
  int n_ent, n_ext, n_rej, n_unf, first_ent, first_ext;

  parking_sensor_tracker dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .tick_100hz (tick_100hz),
    .entry_raw  (entry_raw),
    .exit_raw   (exit_raw),
    .occupied   (occupied),
    .free_slots (free_slots),
    .full       (full),
    .empty      (empty),
    .entry_evt  (entry_evt),
    .exit_evt   (exit_evt),
    .reject     (reject),
    .underflow  (underflow)
  );

  always #5 clk_in = ~clk_in;

  // tick is high for the clock whose rising edge follows a negedge with phase 0
  initial begin
    forever begin
      @(negedge clk_in);
      phase = (phase + 1) % 10;
      tick_100hz = (phase == 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // wait for a rising edge where tick is active
  task automatic align();
    @(posedge clk_in);
    while (phase != 0) @(posedge clk_in);
  endtask

  task automatic sample_pulses(input int i);
    if (entry_evt) begin n_ent++; if (first_ent == 0) first_ent = i; end
    if (exit_evt)  begin n_ext++; if (first_ext == 0) first_ext = i; end
    if (reject)    n_rej++;
    if (underflow) n_unf++;
  endtask

  task automatic clear_counts();
    n_ent = 0; n_ext = 0; n_rej = 0; n_unf = 0; first_ent = 0; first_ext = 0;
  endtask

  // Raise the selected sensors right after a tick edge, hold, release, settle.
  task automatic run(input logic en, input logic ex, input int hold, input int settle);
    clear_counts();
    align();
    @(negedge clk_in);
    entry_raw = en;
    exit_raw  = ex;
    for (int i = 1; i <= hold + settle; i++) begin
      @(posedge clk_in);
      #1;
      sample_pulses(i);
      if (i == hold) begin
        entry_raw = 1'b0;
        exit_raw  = 1'b0;
      end
    end
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_occupied", occupied, 0);
    chk("rst_free", free_slots, 8);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_pulses", {entry_evt, exit_evt, reject, underflow}, 0);
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    rst = 1'b0;

    // single entry: first pulse 2 clk + 4 ticks + 1 clk after the raw rise
    run(1'b1, 1'b0, 60, 60);
    chk("entry1_count", n_ent, 1);
    chk("entry1_latency", first_ent, 41);
    chk("entry1_occupied", occupied, 1);
    chk("entry1_free", free_slots, 7);
    chk("entry1_empty", empty, 0);

    // 3-tick glitch is rejected by the debouncer
    run(1'b1, 1'b0, 30, 60);
    chk("glitch_count", n_ent, 0);
    chk("glitch_occupied", occupied, 1);

    // fill the lot
    for (int k = 2; k <= 8; k++) begin
      run(1'b1, 1'b0, 60, 60);
      chk($sformatf("fill%0d_count", k), n_ent, 1);
      chk($sformatf("fill%0d_occupied", k), occupied, k);
    end
    chk("full_flag", full, 1);
    chk("full_free", free_slots, 0);

    // ninth entry while full
    run(1'b1, 1'b0, 60, 60);
    chk("ninth_reject", n_rej, 1);
    chk("ninth_entry_evt", n_ent, 0);
    chk("ninth_occupied", occupied, 8);

    // simultaneous entry and exit at full
    run(1'b1, 1'b1, 60, 60);
    chk("both_entry_evt", n_ent, 1);
    chk("both_exit_evt", n_ext, 1);
    chk("both_same_cycle", first_ent, first_ext);
    chk("both_occupied", occupied, 8);

    // reset arriving while a reject pulse is high
    align();
    @(negedge clk_in);
    entry_raw = 1'b1;
    repeat (41) @(posedge clk_in);
    #1;
    chk("midpulse_reject_hi", reject, 1);
    @(negedge clk_in);
    rst = 1'b1;
    #1;
    chk("midrst_occupied", occupied, 0);
    chk("midrst_free", free_slots, 8);
    chk("midrst_empty", empty, 1);
    chk("midrst_full", full, 0);
    chk("midrst_pulses", {entry_evt, exit_evt, reject, underflow}, 0);
    entry_raw = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    rst = 1'b0;

    // exit while empty
    run(1'b0, 1'b1, 60, 60);
    chk("underflow_pulse", n_unf, 1);
    chk("underflow_exit_evt", n_ext, 0);
    chk("underflow_occupied", occupied, 0);

    // reset during CONF_HI on entry: no pending event survives
    clear_counts();
    align();
    @(negedge clk_in);
    entry_raw = 1'b1;
    repeat (25) @(posedge clk_in);
    @(negedge clk_in);
    rst = 1'b1;
    entry_raw = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    rst = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk_in);
      #1;
      sample_pulses(i);
    end
    chk("confhi_rst_no_evt", n_ent, 0);
    chk("confhi_rst_occupied", occupied, 0);

    // after release the FSM counts from LOW again with full latency
    run(1'b1, 1'b0, 60, 60);
    chk("restart_count", n_ent, 1);
    chk("restart_latency", first_ent, 41);
    chk("restart_occupied", occupied, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
